// File: rtl/digit_serial_sub.sv
// ---------------------------------------------------------------------------
// digit_serial_sub
//   Multi-cycle subtractor computing diff = a - b - bin (modulo 2^WIDTH).
//   DIGIT bits are handled per clock, least-significant digit first, with
//   a DIGIT-bit ripple slice evaluating a + ~b + carry. Operands arrive on a
//   valid/ready handshake. The result and its flags leave on a second
//   valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width (multiple of DIGIT)
//   DIGIT      bits processed per clock; N = WIDTH/DIGIT cycles per operation
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   in_valid   operands a, b, bin valid
//   in_ready   operands accepted (high only while idle)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       borrow out (unsigned a < b + bin)
//   ovf        signed overflow of the subtraction
//   zero       diff == 0
// ---------------------------------------------------------------------------
module digit_serial_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  diff_r;
  logic              carry_r;
  logic              a_sign_r;
  logic              b_sign_r;
  logic              bout_r;
  logic              ovf_r;
  logic              zero_r;
  logic              last_s;
  logic [DIGIT:0]    slice_s;
  logic [WIDTH-1:0]  diff_shift_s;

  // Signed overflow of a subtraction: operand signs differ and the result
  // sign departs from the minuend sign.
  function automatic logic sub_ovf(input logic a_sign, input logic b_sign,
                                   input logic d_sign);
    sub_ovf = (a_sign != b_sign) && (d_sign != a_sign);
  endfunction

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  assign last_s  = (cnt_r == CW'(N - 1));

  // Ripple slice: subtraction as a + ~b + carry, carry seeded with ~bin.
  assign slice_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, ~b_r[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_r};

  // New digit enters the result register from the MSB side.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign diff_shift_s = slice_s[DIGIT-1:0];
    end else begin : g_multi_digit
      assign diff_shift_s = {slice_s[DIGIT-1:0], diff_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, digit-serial shifting, flag capture on the
  // final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      a_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry_r  <= ~bin;
            cnt_r    <= {CW{1'b0}};
            a_sign_r <= a[WIDTH-1];
            b_sign_r <= b[WIDTH-1];
          end
        end
        ST_BUSY: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= slice_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          diff_r  <= diff_shift_s;
          if (last_s) begin
            // A final carry of 0 means the subtraction needed a borrow.
            bout_r <= ~slice_s[DIGIT];
            ovf_r  <= sub_ovf(a_sign_r, b_sign_r, diff_shift_s[WIDTH-1]);
            zero_r <= ~|diff_shift_s;
          end
        end
        ST_DONE: begin
          // Result and flags held until the consumer takes them.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_sub
//   Three instances of digit_serial_sub (DIGIT = 4, 1, 32 at WIDTH = 32).
//   Directed corner cases and random operands are checked against a plain
//   arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_digit_serial_sub;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  logic [2:0]        in_valid_v;
  logic [2:0]        in_ready_v;
  logic [2:0]        bin_v;
  logic [2:0]        out_valid_v;
  logic [2:0]        out_ready_v;
  logic [2:0]        bout_v;
  logic [2:0]        ovf_v;
  logic [2:0]        zero_v;
  logic [2:0][W-1:0] a_v;
  logic [2:0][W-1:0] b_v;
  logic [2:0][W-1:0] diff_v;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    digit_serial_sub #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .a        (a_v[g]),
      .b        (b_v[g]),
      .bin      (bin_v[g]),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .diff     (diff_v[g]),
      .bout     (bout_v[g]),
      .ovf      (ovf_v[g]),
      .zero     (zero_v[g])
    );
  end

  function automatic int digit_of(input int idx);
    case (idx)
      0:       digit_of = 4;
      1:       digit_of = 1;
      default: digit_of = 32;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact 33-bit arithmetic; borrow is the sign of the wide result.
  task automatic ref_model(input logic [31:0] ia, input logic [31:0] ib,
                           input logic ibin, output logic [31:0] d,
                           output logic bo, output logic ov, output logic z);
    logic [32:0] full;
    full = {1'b0, ia} - {1'b0, ib} - {32'd0, ibin};
    d    = full[31:0];
    bo   = full[32];
    ov   = (ia[31] != ib[31]) && (d[31] != ia[31]);
    z    = (d == 32'd0);
  endtask

  // Wait (bounded) for in_ready, then present operands. Time base: #1 after posedge.
  task automatic present(input int idx, input logic [31:0] ia,
                         input logic [31:0] ib, input logic ibin,
                         input string pre);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (in_ready_v[idx]) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq({pre, "_in_ready"}, {63'd0, got}, 64'd1);
    a_v[idx]        = ia;
    b_v[idx]        = ib;
    bin_v[idx]      = ibin;
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    a_v[idx]        = $urandom;
    b_v[idx]        = $urandom;
    bin_v[idx]      = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(input int idx, input logic [31:0] ia,
                       input logic [31:0] ib, input logic ibin,
                       input int hold, input string pre);
    logic [31:0] ed;
    logic eb, eo, ez;
    int lat;
    ref_model(ia, ib, ibin, ed, eb, eo, ez);
    present(idx, ia, ib, ibin, pre);
    check_eq({pre, "_busy_ready"}, {63'd0, in_ready_v[idx]}, 64'd0);
    lat = 0;
    while (lat < 40 && !out_valid_v[idx]) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({pre, "_latency"}, 64'(lat), 64'(32 / digit_of(idx)));
    check_eq({pre, "_diff"}, {32'd0, diff_v[idx]}, {32'd0, ed});
    check_eq({pre, "_bout"}, {63'd0, bout_v[idx]}, {63'd0, eb});
    check_eq({pre, "_ovf"}, {63'd0, ovf_v[idx]}, {63'd0, eo});
    check_eq({pre, "_zero"}, {63'd0, zero_v[idx]}, {63'd0, ez});
    check_eq({pre, "_done_ready"}, {63'd0, in_ready_v[idx]}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid_v[idx] = 1'b1;
      a_v[idx]        = $urandom;
      b_v[idx]        = $urandom;
      @(posedge clk); #1;
      check_eq({pre, "_hold_valid"}, {63'd0, out_valid_v[idx]}, 64'd1);
      check_eq({pre, "_hold_ready"}, {63'd0, in_ready_v[idx]}, 64'd0);
      check_eq({pre, "_hold_diff"}, {32'd0, diff_v[idx]}, {32'd0, ed});
      check_eq({pre, "_hold_flags"},
               {61'd0, bout_v[idx], ovf_v[idx], zero_v[idx]},
               {61'd0, eb, eo, ez});
    end
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
    check_eq({pre, "_rel_valid"}, {63'd0, out_valid_v[idx]}, 64'd0);
    check_eq({pre, "_rel_ready"}, {63'd0, in_ready_v[idx]}, 64'd1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       rnd_val = 32'($urandom_range(0, 15));
      1:       rnd_val = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      2:       rnd_val = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: rnd_val = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic        tbi[7];
    logic [31:0] ra, rb;
    string pre;
    ta  = '{32'd10, 32'd3, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5, 32'd5};
    tb  = '{32'd3, 32'd10, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd4};
    tbi = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n       = 1'b0;
    in_valid_v  = 3'b000;
    out_ready_v = 3'b000;
    bin_v       = 3'b000;
    a_v         = '0;
    b_v         = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pre = $sformatf("rst_d%0d", digit_of(i));
      check_eq({pre, "_ready"}, {63'd0, in_ready_v[i]}, 64'd1);
      check_eq({pre, "_outs"},
               {28'd0, diff_v[i], out_valid_v[i], bout_v[i], ovf_v[i], zero_v[i]},
               64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases on every digit size.
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 7; t++) begin
        pre = $sformatf("dir_d%0d_t%0d", digit_of(i), t);
        do_op(i, ta[t], tb[t], tbi[t], 0, pre);
      end
    end

    // Consumer stall in DONE with in_valid pulsed meanwhile.
    do_op(0, 32'd10, 32'd3, 1'b0, 5, "stall_d4");

    // Reset while busy, then a fresh operation.
    present(0, 32'd1234, 32'd77, 1'b0, "abort_d4");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", {63'd0, out_valid_v[0]}, 64'd0);
    check_eq("abort_ready", {63'd0, in_ready_v[0]}, 64'd1);
    check_eq("abort_diff", {32'd0, diff_v[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 32'd100, 32'd1, 1'b0, 0, "post_abort_d4");

    // Random operands with random consumer stalls.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 20; r++) begin
        ra = rnd_val();
        rb = ($urandom_range(0, 4) == 0) ? ra : rnd_val();
        pre = $sformatf("rnd_d%0d_%0d", digit_of(i), r);
        do_op(i, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), pre);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
